// File: rtl/io_port_bank.sv
// io_port_bank: bank of NUM_PORTS memory-mapped 8-bit output ports plus
// one control register holding per-port blink enables.
//   port i  at BASE_ADDR + i  (i < NUM_PORTS)
//   control at BASE_ADDR + 8
// A write commits once per rising edge of wr, so a CPU that holds wr for many
// cycles still produces a single store. Blinking ports are blanked to 8'h00
// during the off half of a BLINK_DIV-cycle half-period square wave.
// Optional feature macro: IO_PORT_READBACK_EN drives rdata for reads of the
// implemented registers. Without it rdata stays released (8'hzz).
module io_port_bank #(
    parameter logic [15:0] BASE_ADDR = 16'hfff0,
    parameter int          NUM_PORTS = 4,
    parameter int          BLINK_DIV = 2095000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            a,
    input  logic [7:0]             wdata,
    input  logic                   rd,
    input  logic                   wr,
    output logic [7:0]             rdata,
    output logic [8*NUM_PORTS-1:0] port_out,
    output logic                   hit
);

    localparam int          CNT_W     = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [15:0] CTRL_ADDR = BASE_ADDR + 16'd8;

    logic [NUM_PORTS-1:0]   w_port_sel;
    logic                   w_ctrl_sel;
    logic                   w_hit;
    logic                   w_commit;
    logic                   w_cnt_wrap;

    logic                   r_wr_q;
    logic [7:0]             r_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]   r_blink_en;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_phase;
    logic [8*NUM_PORTS-1:0] r_port_out;

    // Address decode: one select per implemented port plus the control register.
    always_comb begin
        w_port_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (a == BASE_ADDR + 16'(i)) begin
                w_port_sel[i] = 1'b1;
            end
        end
        w_ctrl_sel = (a == CTRL_ADDR);
    end

    assign w_hit      = (|w_port_sel) | w_ctrl_sel;
    assign hit        = w_hit;
    // Only the first cycle of a wr level counts; address changes under a
    // held wr therefore never produce a second store.
    assign w_commit   = wr & ~r_wr_q & w_hit;
    assign w_cnt_wrap = (r_cnt == CNT_LAST);

    // Previous-cycle wr. Loaded from wr even during reset so a strobe already
    // high when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        r_wr_q <= wr;
    end

    // Port data registers: cleared by reset, written on a committed port write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_data[i] <= 8'h00;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_port_sel[i]) begin
                    r_data[i] <= wdata;
                end
            end
        end
    end

    // Blink enables: low NUM_PORTS bits of a committed control write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_en <= '0;
        end else if (w_commit && w_ctrl_sel) begin
            r_blink_en <= wdata[NUM_PORTS-1:0];
        end
    end

    // Blink timebase: free-running divider toggling phase on wrap; a control
    // write restarts it in the visible (phase=1) half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_commit && w_ctrl_sel) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_cnt_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Registered outputs: stored data, blanked for enabled ports in the off phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port_out <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_port_out[8*i +: 8] <= (!r_blink_en[i] || r_phase) ? r_data[i] : 8'h00;
            end
        end
    end

    assign port_out = r_port_out;

`ifdef IO_PORT_READBACK_EN
    logic [7:0] w_rd_val;

    // Readback mux: unblanked port data, or blink enables zero-extended.
    always_comb begin
        w_rd_val = 8'h00;
        if (w_ctrl_sel) begin
            w_rd_val = 8'(r_blink_en);
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_port_sel[i]) begin
                w_rd_val = r_data[i];
            end
        end
    end

    assign rdata = (rd && w_hit) ? w_rd_val : 8'hzz;
`else
    logic w_unused_rd;

    assign w_unused_rd = rd;
    assign rdata       = 8'hzz;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank (NUM_PORTS=4, BLINK_DIV=4).
// Readback checks are included when IO_PORT_READBACK_EN is defined.
module tb_io_port_bank;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  wdata;
    logic        rd;
    logic        wr;
    wire  [7:0]  rdata;
    logic [31:0] port_out;
    logic        hit;

    int n_tests = 0;
    int n_fail  = 0;

    io_port_bank #(
        .BASE_ADDR (16'hfff0),
        .NUM_PORTS (4),
        .BLINK_DIV (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .wdata    (wdata),
        .rd       (rd),
        .wr       (wr),
        .rdata    (rdata),
        .port_out (port_out),
        .hit      (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A released bus reads as z in a four-state simulator and as 0 in a
    // two-state one; a driven value is nonzero at every point this is used.
    task automatic chk_rel(input string tag);
        n_tests++;
        assert ((rdata === 8'hzz) || (rdata === 8'h00)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected zz", tag, rdata);
        end
    endtask

    initial begin
        logic [7:0] exp_lo;

        rst = 1'b1; a = 16'h0000; wdata = 8'h00; rd = 1'b0; wr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_port_out", port_out, 32'h0000_0000);
        chk("reset_hit_none", {31'd0, hit}, 32'd0);
        chk_rel("reset_rdata");

        // Held write to port 2 commits once, visible one edge later.
        a = 16'hfff2; wdata = 8'h5a; wr = 1'b1;
        #1;
        chk("hit_port2", {31'd0, hit}, 32'd1);
        tick();
        chk("wr_latency_before", port_out, 32'h0000_0000);
        tick();
        chk("wr_port2_visible", port_out, 32'h005a_0000);
        wdata = 8'h77;
        tick();
        chk("wr_held_once", port_out, 32'h005a_0000);
        wr = 1'b0;
        tick();
        chk("wr_release", port_out, 32'h005a_0000);

        // Address moves under held wr: only port 0 takes the data.
        a = 16'hfff0; wdata = 8'h33; wr = 1'b1;
        tick();
        a = 16'hfff1;
        tick();
        tick();
        wr = 1'b0;
        tick();
        chk("addr_move_held", port_out, 32'h005a_0033);

        // Decode boundaries.
        a = 16'hfff3; #1; chk("hit_fff3", {31'd0, hit}, 32'd1);
        a = 16'hfff4; #1; chk("hit_fff4", {31'd0, hit}, 32'd0);
        a = 16'hfff8; #1; chk("hit_ctrl", {31'd0, hit}, 32'd1);
        a = 16'hffef; #1; chk("hit_ffef", {31'd0, hit}, 32'd0);

        // Unimplemented addresses: no hit, no state change, bus released.
        a = 16'hfff5; wdata = 8'hee; wr = 1'b1; rd = 1'b1;
        #1;
        chk("hit_fff5", {31'd0, hit}, 32'd0);
        chk_rel("rdata_fff5");
        tick();
        wr = 1'b0;
        tick();
        a = 16'hfff9; wr = 1'b1;
        #1;
        chk("hit_fff9", {31'd0, hit}, 32'd0);
        chk_rel("rdata_fff9");
        tick();
        wr = 1'b0; rd = 1'b0;
        tick();
        tick();
        chk("nohit_no_change", port_out, 32'h005a_0033);

        // Reset coincident with a write edge; wr still high afterwards.
        rst = 1'b1; a = 16'hfff1; wdata = 8'hc3; wr = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_wins", port_out, 32'h0000_0000);
        tick();
        tick();
        wr = 1'b0;
        tick();
        chk("held_after_rst", port_out, 32'h0000_0000);
        a = 16'hfff1; wdata = 8'h11; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        chk("wr_after_rst", port_out, 32'h0000_1100);

        // Blink port 0 with a 4-cycle half-period.
        a = 16'hfff0; wdata = 8'hff; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        chk("port0_ff", port_out, 32'h0000_11ff);
        a = 16'hfff8; wdata = 8'hf1; wr = 1'b1;
        tick();
        wr = 1'b0;
        chk("blink_k0", port_out, 32'h0000_11ff);
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_lo = ((((k - 1) / 4) % 2) == 0) ? 8'hff : 8'h00;
            chk($sformatf("blink_k%0d", k), port_out, {16'h0000, 8'h11, exp_lo});
`ifdef IO_PORT_READBACK_EN
            if (k == 6) begin
                rd = 1'b1; a = 16'hfff0;
                #1; chk("rb_port0_off", {24'd0, rdata}, 32'h0000_00ff);
                a = 16'hfff8;
                #1; chk("rb_ctrl", {24'd0, rdata}, 32'h0000_0001);
                a = 16'hfff1;
                #1; chk("rb_port1", {24'd0, rdata}, 32'h0000_0011);
                rd = 1'b0;
                #1; chk_rel("rb_rd_low");
            end
`endif
        end

        // Clearing the blink enables restores steady output.
        a = 16'hfff8; wdata = 8'h00; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        tick();
        chk("blink_off", port_out, 32'h0000_11ff);
        tick();
        tick();
        tick();
        chk("blink_off_steady", port_out, 32'h0000_11ff);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
